// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALUOp/ALUControl encodings, NOP and decode helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rv32i_pkg;

    // Base-ISA major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Instruction class handed to EX
    typedef enum logic [2:0] {
        ALUOP_NONE   = 3'b000,
        ALUOP_BRANCH = 3'b001,
        ALUOP_RTYPE  = 3'b010,
        ALUOP_ITYPE  = 3'b011,
        ALUOP_LDST   = 3'b100,
        ALUOP_JAL    = 3'b101,
        ALUOP_JALR   = 3'b110,
        ALUOP_UPPER  = 3'b111
    } alu_op_e;

    // ALU operation select
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLL   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_SLT   = 4'b1000,
        ALU_SLTU  = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_ctl_e;

    // Decoded control bundle for one instruction
    typedef struct packed {
        logic     reg_write;
        logic     mem_read;
        logic     mem_write;
        logic     mem_to_reg;
        logic     branch;
        logic     jump;
        logic     alu_src;
        alu_op_e  alu_op;
        alu_ctl_e alu_ctl;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        jump:       1'b0,
        alu_src:    1'b0,
        alu_op:     ALUOP_NONE,
        alu_ctl:    ALU_ADD
    };

    // funct3/funct7[5] to ALU op for OP and OP-IMM; SUB only exists in the register form
    function automatic alu_ctl_e arith_ctl(input logic [2:0] funct3,
                                           input logic       f7b5,
                                           input logic       is_reg);
        alu_ctl_e ctl;
        case (funct3)
            3'b000:  ctl = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            default: ctl = ALU_AND;
        endcase
        return ctl;
    endfunction

    // Immediate for the instruction's format; formats without an immediate give 0
    function automatic logic [31:0] imm_gen(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {instr[31:12], 12'b0};
            OP_JAL:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'b0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 integer register file, two read ports, one write port, x0 hardwired to zero.
// Latency: reads combinational with same-cycle write-through bypass; writes land on the clock edge.
// Backpressure: none; the write port is always accepted.
module id_stage_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Next register contents: single write, never to x0
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
    end

    // Register array with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: x0 reads zero, a same-cycle WB write to the read index is forwarded
    always_comb begin
        rdata1 = regs_q[raddr1];
        rdata2 = regs_q[raddr2];
        if (raddr1 == '0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == '0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: IF/ID register, register file, decode/immediates, load-use hazard control.
// Latency: 1 cycle from the IF inputs into IF/ID, 0 cycles from IF/ID to the ID/EX-facing outputs.
// Backpressure: load-use hazard raises stall_f (IF/ID held) and flush_e; redirect_x overrides and squashes.
// Build option: define ID_ILLEGAL_DETECT_EN to build illegal-instruction detection (illegal_d).
module id_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    input  logic [31:0]     instr_f,
    input  logic            valid_f,
    input  logic            redirect_x,
    input  logic            MemRead_x,
    input  logic [4:0]      rd_ex,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_f,
    output logic            flush_e,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] rs1_d,
    output logic [XLEN-1:0] rs2_d,
    output logic [XLEN-1:0] imm_d,
    output logic [4:0]      rs1_id,
    output logic [4:0]      rs2_id,
    output logic [4:0]      rd_id,
    output logic            RegWrite_d,
    output logic            MemRead_d,
    output logic            MemWrite_d,
    output logic            MemToReg_d,
    output logic            Branch_d,
    output logic            Jump_d,
    output logic            ALUSrc_d,
    output logic [2:0]      ALUOp_d,
    output logic [3:0]      ALUControl_d,
    output logic            illegal_d
);

    import rv32i_pkg::*;

    // IF/ID pipeline register
    logic [XLEN-1:0] ifid_pc_q,    ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [4:0] rs1, rs2;

    logic  use_rs1, use_rs2;
    logic  hz;
    logic  known;
    ctrl_t dec;
    ctrl_t ctrl;

    assign opcode = ifid_instr_q[6:0];
    assign funct3 = ifid_instr_q[14:12];
    assign f7b5   = ifid_instr_q[30];
    assign rs1    = ifid_instr_q[19:15];
    assign rs2    = ifid_instr_q[24:20];

    // Load-use hazard: EX load targets a source this instruction actually reads
    always_comb begin
        use_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        use_rs2 = (opcode == OP_OP) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
        hz = ifid_valid_q && MemRead_x && (rd_ex != 5'd0) &&
             ((use_rs1 && (rs1 == rd_ex)) || (use_rs2 && (rs2 == rd_ex)));
    end

    // A redirect squashes the stalled instruction, so it must not also freeze IF
    assign stall_f = hz && !redirect_x;
    assign flush_e = hz || redirect_x;

    // IF/ID next state: redirect invalidates, hazard holds, otherwise load from IF
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect_x) begin
            ifid_valid_d = 1'b0;
        end else if (!hz) begin
            ifid_pc_d    = pc_f;
            ifid_instr_d = instr_f;
            ifid_valid_d = valid_f;
        end
    end

    // IF/ID register; resets to an invalid NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    id_stage_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_d),
        .rdata2 (rs2_d)
    );

    // Raw control decode by opcode, before validity gating
    always_comb begin
        dec   = CTRL_BUBBLE;
        known = 1'b1;
        case (opcode)
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.alu_src    = 1'b1;
                dec.alu_op     = ALUOP_LDST;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_LDST;
            end
            OP_BRANCH: begin
                dec.branch  = 1'b1;
                dec.alu_op  = ALUOP_BRANCH;
                dec.alu_ctl = ALU_SUB;
            end
            OP_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_JAL;
            end
            OP_JALR: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_JALR;
            end
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_UPPER;
                dec.alu_ctl   = ALU_PASSB;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_UPPER;
            end
            OP_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = ALUOP_RTYPE;
                dec.alu_ctl   = arith_ctl(funct3, f7b5, 1'b1);
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = ALUOP_ITYPE;
                dec.alu_ctl   = arith_ctl(funct3, f7b5, 1'b0);
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

`ifdef ID_ILLEGAL_DETECT_EN
    logic [6:0] funct7;
    logic       bad;

    assign funct7 = ifid_instr_q[31:25];

    // Reject unknown opcodes and funct3/funct7 combinations outside RV32I
    always_comb begin
        bad = 1'b0;
        case (opcode)
            OP_OP: begin
                bad = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_IMM: begin
                if (funct3 == 3'b001) begin
                    bad = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    bad = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
                end
            end
            OP_LOAD:   bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            OP_STORE:  bad = funct3[2] || (funct3 == 3'b011);
            OP_BRANCH: bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            OP_JALR:   bad = (funct3 != 3'b000);
            OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
    end

    assign illegal_d = ifid_valid_q && bad;

    // Bubble when invalid, unknown or illegal
    always_comb begin
        ctrl = CTRL_BUBBLE;
        if (ifid_valid_q && known && !bad) begin
            ctrl = dec;
        end
    end
`else
    assign illegal_d = 1'b0;

    // Bubble when invalid or unknown
    always_comb begin
        ctrl = CTRL_BUBBLE;
        if (ifid_valid_q && known) begin
            ctrl = dec;
        end
    end
`endif

    // Data outputs follow IF/ID regardless of validity; EX ignores them under a bubble
    assign pc_d   = ifid_pc_q;
    assign imm_d  = imm_gen(ifid_instr_q);
    assign rs1_id = rs1;
    assign rs2_id = rs2;
    assign rd_id  = ifid_instr_q[11:7];

    assign RegWrite_d   = ctrl.reg_write;
    assign MemRead_d    = ctrl.mem_read;
    assign MemWrite_d   = ctrl.mem_write;
    assign MemToReg_d   = ctrl.mem_to_reg;
    assign Branch_d     = ctrl.branch;
    assign Jump_d       = ctrl.jump;
    assign ALUSrc_d     = ctrl.alu_src;
    assign ALUOp_d      = ctrl.alu_op;
    assign ALUControl_d = ctrl.alu_ctl;

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f, instr_f;
    logic        valid_f, redirect_x, MemRead_x;
    logic [4:0]  rd_ex;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_f, flush_e;
    logic [31:0] pc_d, rs1_d, rs2_d, imm_d;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic        RegWrite_d, MemRead_d, MemWrite_d, MemToReg_d, Branch_d, Jump_d, ALUSrc_d;
    logic [2:0]  ALUOp_d;
    logic [3:0]  ALUControl_d;
    logic        illegal_d;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .reset(reset), .pc_f(pc_f), .instr_f(instr_f), .valid_f(valid_f),
        .redirect_x(redirect_x), .MemRead_x(MemRead_x), .rd_ex(rd_ex),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_f(stall_f), .flush_e(flush_e),
        .pc_d(pc_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .imm_d(imm_d),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .RegWrite_d(RegWrite_d), .MemRead_d(MemRead_d), .MemWrite_d(MemWrite_d),
        .MemToReg_d(MemToReg_d), .Branch_d(Branch_d), .Jump_d(Jump_d), .ALUSrc_d(ALUSrc_d),
        .ALUOp_d(ALUOp_d), .ALUControl_d(ALUControl_d), .illegal_d(illegal_d)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [6:0]  ctl;     // {RegWrite, MemRead, MemWrite, MemToReg, Branch, Jump, ALUSrc}
        logic [2:0]  aluop;
        logic [3:0]  aluctl;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } vec_t;

    localparam int NV = 16;
    vec_t        vecs [NV];
    vec_t        sb_q [$];
    logic [31:0] mdl_regs [32];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic valid,
                                input logic [6:0] ctl, input logic [2:0] aluop, input logic [3:0] aluctl,
                                input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic ill);
        vec_t v;
        v.pc = pc; v.instr = instr; v.valid = valid; v.ctl = ctl; v.aluop = aluop;
        v.aluctl = aluctl; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.ill = ill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_vec();
        return {RegWrite_d, MemRead_d, MemWrite_d, MemToReg_d, Branch_d, Jump_d, ALUSrc_d};
    endfunction

    task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        wb_we = 1'b1; wb_rd = rd; wb_data = data;
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        if (rd != 5'd0) mdl_regs[rd] = data;
    endtask

    // Load one valid instruction into IF/ID; returns #1 after the capturing edge
    task automatic load_ifid(input logic [31:0] pc, input logic [31:0] instr);
        @(negedge clk);
        pc_f = pc; instr_f = instr; valid_f = 1'b1;
        @(posedge clk);
        #1;
        valid_f = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t e;
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'h0;

        // ctl, aluop, aluctl, imm, rs1, rs2, rd, illegal
        vecs[0]  = mk(32'h0000_0040, 32'hFFD0_8293, 1, 7'b1000001, 3'b011, 4'b0000, 32'hFFFF_FFFD, 1, 29, 5, 0);  // addi x5,x1,-3
        vecs[1]  = mk(32'h0000_0044, 32'h0022_8333, 1, 7'b1000000, 3'b010, 4'b0000, 32'h0,         5, 2, 6, 0);   // add x6,x5,x2
        vecs[2]  = mk(32'h0000_0048, 32'h4020_83B3, 1, 7'b1000000, 3'b010, 4'b0001, 32'h0,         1, 2, 7, 0);   // sub x7,x1,x2
        vecs[3]  = mk(32'h0000_004C, 32'h00C0_A403, 1, 7'b1101001, 3'b100, 4'b0000, 32'h0000_000C, 1, 12, 8, 0);  // lw x8,12(x1)
        vecs[4]  = mk(32'h0000_0050, 32'hFE20_AE23, 1, 7'b0010001, 3'b100, 4'b0000, 32'hFFFF_FFFC, 1, 2, 28, 0);  // sw x2,-4(x1)
        vecs[5]  = mk(32'h0000_0054, 32'hFE20_8CE3, 1, 7'b0000100, 3'b001, 4'b0001, 32'hFFFF_FFF8, 1, 2, 25, 0);  // beq x1,x2,-8
        vecs[6]  = mk(32'h0000_0058, 32'h0100_00EF, 1, 7'b1000010, 3'b101, 4'b0000, 32'h0000_0010, 0, 16, 1, 0);  // jal x1,+16
        vecs[7]  = mk(32'h0000_005C, 32'h0040_8067, 1, 7'b1000011, 3'b110, 4'b0000, 32'h0000_0004, 1, 4, 0, 0);   // jalr x0,4(x1)
        vecs[8]  = mk(32'h0000_0060, 32'h1234_5537, 1, 7'b1000001, 3'b111, 4'b1010, 32'h1234_5000, 8, 3, 10, 0);  // lui x10
        vecs[9]  = mk(32'h0000_0064, 32'hFFFF_F597, 1, 7'b1000001, 3'b111, 4'b0000, 32'hFFFF_F000, 31, 31, 11, 0); // auipc x11
        vecs[10] = mk(32'h0000_0068, 32'h4032_D613, 1, 7'b1000001, 3'b011, 4'b0111, 32'h0000_0403, 5, 3, 12, 0);  // srai x12,x5,3
        vecs[11] = mk(32'h0000_006C, 32'h0020_B6B3, 1, 7'b1000000, 3'b010, 4'b1001, 32'h0,         1, 2, 13, 0);  // sltu x13,x1,x2
        vecs[12] = mk(32'h0000_0070, 32'hFFF0_C793, 1, 7'b1000001, 3'b011, 4'b0100, 32'hFFFF_FFFF, 1, 31, 15, 0); // xori x15,x1,-1
        vecs[13] = mk(32'h0000_0074, 32'h4020_D4B3, 1, 7'b1000000, 3'b010, 4'b0111, 32'h0,         1, 2, 9, 0);   // sra x9,x1,x2
        vecs[14] = mk(32'h0000_0078, 32'h0000_0073, 1, 7'b0000000, 3'b000, 4'b0000, 32'h0,         0, 0, 0, 1);   // ecall (unknown)
        vecs[15] = mk(32'h0000_007C, 32'h0022_8333, 0, 7'b0000000, 3'b000, 4'b0000, 32'h0,         5, 2, 6, 0);   // add, not valid

        reset = 1'b1; pc_f = 32'h1111_2222; instr_f = 32'h0022_8333; valid_f = 1'b1;
        redirect_x = 1'b0; MemRead_x = 1'b0; rd_ex = 5'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;

        // Reset: two cycles, then outputs reflect an invalid NOP
        repeat (2) @(posedge clk);
        @(negedge clk);
        valid_f = 1'b0;
        chk("reset_ctl", {25'b0, ctl_vec()}, 32'h0);
        chk("reset_aluop", {29'b0, ALUOp_d}, 32'h0);
        chk("reset_aluctl", {28'b0, ALUControl_d}, 32'h0);
        chk("reset_stall_f", {31'b0, stall_f}, 32'h0);
        chk("reset_flush_e", {31'b0, flush_e}, 32'h0);
        chk("reset_rs1_d", rs1_d, 32'h0);
        chk("reset_pc_d", pc_d, 32'h0);
        chk("reset_imm_d", imm_d, 32'h0);
        chk("reset_rd_id", {27'b0, rd_id}, 32'h0);
        reset = 1'b0;

        wb_write(5'd1, 32'd10);
        wb_write(5'd2, 32'd7);
        wb_write(5'd5, 32'h0000_0055);

        // Table-driven decode through a scoreboard
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pc_f = vecs[i].pc; instr_f = vecs[i].instr; valid_f = vecs[i].valid;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d_ctl", i), {25'b0, ctl_vec()}, {25'b0, e.ctl});
                chk($sformatf("v%0d_aluop", i), {29'b0, ALUOp_d}, {29'b0, e.aluop});
                chk($sformatf("v%0d_aluctl", i), {28'b0, ALUControl_d}, {28'b0, e.aluctl});
                chk($sformatf("v%0d_imm", i), imm_d, e.imm);
                chk($sformatf("v%0d_ids", i), {17'b0, rs1_id, rs2_id, rd_id}, {17'b0, e.rs1, e.rs2, e.rd});
                chk($sformatf("v%0d_rs1_d", i), rs1_d, mdl_regs[e.rs1]);
                chk($sformatf("v%0d_rs2_d", i), rs2_d, mdl_regs[e.rs2]);
                chk($sformatf("v%0d_pc_d", i), pc_d, e.pc);
`ifdef ID_ILLEGAL_DETECT_EN
                chk($sformatf("v%0d_illegal", i), {31'b0, illegal_d}, {31'b0, e.ill & e.valid});
`else
                chk($sformatf("v%0d_illegal", i), {31'b0, illegal_d}, 32'h0);
`endif
                chk($sformatf("v%0d_stall_flush", i), {30'b0, stall_f, flush_e}, 32'h0);
            end
        end

        // Load-use: add x6,x5,x2 in IF/ID, load to x5 in EX
        load_ifid(32'h0000_0100, 32'h0022_8333);
        MemRead_x = 1'b1; rd_ex = 5'd5;
        pc_f = 32'h0000_0104; instr_f = 32'h4020_83B3; valid_f = 1'b1;
        #1;
        chk("lu_stall_f", {31'b0, stall_f}, 32'h1);
        chk("lu_flush_e", {31'b0, flush_e}, 32'h1);
        @(posedge clk);
        #1;
        chk("lu_hold_pc", pc_d, 32'h0000_0100);
        chk("lu_hold_rd", {27'b0, rd_id}, 32'd6);
        chk("lu_hold_regwrite", {31'b0, RegWrite_d}, 32'h1);
        rd_ex = 5'd2;
        #1;
        chk("lu_rs2_stall", {31'b0, stall_f}, 32'h1);
        rd_ex = 5'd0;
        #1;
        chk("lu_rd0_stall_flush", {30'b0, stall_f, flush_e}, 32'h0);
        rd_ex = 5'd7;
        #1;
        chk("lu_nomatch_stall", {31'b0, stall_f}, 32'h0);

        // Redirect coincident with a hazard: redirect wins
        rd_ex = 5'd5; redirect_x = 1'b1;
        #1;
        chk("rd_stall_f", {31'b0, stall_f}, 32'h0);
        chk("rd_flush_e", {31'b0, flush_e}, 32'h1);
        @(posedge clk);
        #1;
        redirect_x = 1'b0; valid_f = 1'b0;
        #1;
        chk("rd_bubble_ctl", {25'b0, ctl_vec()}, 32'h0);
        chk("rd_bubble_aluop", {29'b0, ALUOp_d}, 32'h0);
        chk("rd_invalid_no_hz", {30'b0, stall_f, flush_e}, 32'h0);
        MemRead_x = 1'b0;

        // LUI reads neither source: matching its rs1/rs2 fields must not stall
        load_ifid(32'h0000_0200, 32'h1234_5537);
        MemRead_x = 1'b1; rd_ex = 5'd8;
        #1;
        chk("lui_rs1_nostall", {31'b0, stall_f}, 32'h0);
        rd_ex = 5'd3;
        #1;
        chk("lui_rs2_nostall", {31'b0, stall_f}, 32'h0);
        MemRead_x = 1'b0; rd_ex = 5'd0;

        // WB bypass on rs1: addi x4,x3,0
        load_ifid(32'h0000_0300, 32'h0001_8213);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        #1;
        chk("byp_rs1_same_cycle", rs1_d, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        mdl_regs[3] = 32'hDEAD_BEEF;
        #1;
        chk("byp_rs1_committed", rs1_d, mdl_regs[3]);

        // WB bypass on rs2: add x6,x5,x2
        load_ifid(32'h0000_0304, 32'h0022_8333);
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hCAFE_F00D;
        #1;
        chk("byp_rs2_same_cycle", rs2_d, 32'hCAFE_F00D);
        chk("byp_rs1_unaffected", rs1_d, mdl_regs[5]);
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        mdl_regs[2] = 32'hCAFE_F00D;

        // x0 protection: addi x4,x0,0 while WB writes x0
        load_ifid(32'h0000_0308, 32'h0000_0213);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
        #1;
        chk("x0_no_bypass", rs1_d, 32'h0);
        @(posedge clk);
        #1;
        wb_we = 1'b0;
        #1;
        chk("x0_after_write", rs1_d, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the RV32I 5-stage pipeline, directly upstream of the ID/EX pipeline register.
- Contains three parts:
  - the IF/ID pipeline register (PC, instruction, valid);
  - the 32x32 register file, with its write port driven from WB;
  - instruction decode and immediate generation.
- Detects load-use hazards and generates the stall/flush controls for IF, IF/ID and ID/EX.
- Outputs are named and sized to connect one-to-one onto the ID/EX register's *_d / *_id inputs.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- NREGS, 32, register count; index width is 5.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_f  in  32  PC of the fetched instruction.
- instr_f  in  32  fetched instruction word.
- valid_f  in  1  fetched word is valid.
- redirect_x  in  1  EX has resolved a taken branch or jump; squash younger instructions.
- MemRead_x  in  1  instruction in EX is a load.
- rd_ex  in  5  destination register of the instruction in EX.
- wb_we  in  1  register-file write enable from WB.
- wb_rd  in  5  WB destination register.
- wb_data  in  32  WB write data.
- stall_f  out  1  hold PC / IF.
- flush_e  out  1  drives the ID/EX flush input.
- pc_d, rs1_d, rs2_d, imm_d  out  32 each  data to ID/EX.
- rs1_id, rs2_id, rd_id  out  5 each  register indices.
- RegWrite_d, MemRead_d, MemWrite_d, MemToReg_d, Branch_d, Jump_d, ALUSrc_d  out  1 each  control signals.
- ALUOp_d  out  3  instruction class.
- ALUControl_d  out  4  ALU operation.
- illegal_d  out  1  illegal instruction (optional feature; otherwise tied 0).

Behaviour:
- IF/ID register (pc_q, instr_q, valid_q), updated on the clock edge by priority:
  1. reset: clear all fields; instr_q = 0x00000013 (NOP).
  2. redirect_x: valid_q = 0.
  3. load-use stall: hold all fields.
  4. otherwise: load pc_f, instr_f, valid_f.
- Load-use hazard, combinational:
  - hz = valid_q & MemRead_x & (rd_ex != 0) & ((use_rs1 & rs1 == rd_ex) | (use_rs2 & rs2 == rd_ex)).
  - use_rs1 is false for LUI, AUIPC and JAL.
  - use_rs2 is true only for R-type, store and branch.
- stall_f = hz & ~redirect_x.
- flush_e = hz | redirect_x.
- Simultaneous redirect_x and hz: redirect wins. IF/ID is invalidated, not held; stall_f = 0.
- Register file:
  - Written on the clock edge when wb_we & (wb_rd != 0).
  - x0 always reads 0.
  - reset clears all registers to 0.
  - Write-through bypass: if wb_we & wb_rd == rs & rs != 0, rs*_d = wb_data in the same cycle.
- Decode is purely combinational from the IF/ID register; latency is 0 cycles from the IF/ID register to the outputs.
  - pc_d = pc_q.
  - rs1_id, rs2_id, rd_id = instr fields [19:15], [24:20], [11:7].
- Immediate generation by opcode:
  - I-type: sign-extended I immediate.
  - S-type: S immediate.
  - B-type: B immediate, bit 0 = 0.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: J immediate, bit 0 = 0.
  - Other opcodes: imm_d = 0.
- ALUOp encoding:
  - 000 none
  - 001 branch
  - 010 R-type
  - 011 I-type ALU
  - 100 load/store
  - 101 JAL
  - 110 JALR
  - 111 LUI/AUIPC
- ALUControl encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR
  - 0101 SLL, 0110 SRL, 0111 SRA
  - 1000 SLT, 1001 SLTU, 1010 PASSB
  - SUB is selected only for R-type with funct7[5] = 1.
  - SRA is selected for funct7[5] = 1 on shifts.
  - Branch instructions use SUB.
- Control by instruction:
  - Load: RegWrite, MemRead, MemToReg, ALUSrc.
  - Store: MemWrite, ALUSrc.
  - Branch: Branch.
  - JAL / JALR: Jump, RegWrite; JALR also sets ALUSrc.
  - LUI: RegWrite, ALUSrc, PASSB.
  - AUIPC: RegWrite, ALUSrc, ADD.
- When valid_q = 0, or the opcode is unknown, all control outputs are 0 (bubble).
- Reset: every control output and stall_f/flush_e are 0 in the cycle after reset. Data outputs reflect the NOP (all 0, except the NOP's imm = 0).

Optional Feature:
- Macro ID_ILLEGAL_DETECT_EN.
- Defined:
  - illegal_d = valid_q & (unknown opcode, or bad funct3/funct7 combination).
  - On an illegal instruction, control outputs are forced to 0.
- Undefined: illegal_d is tied to 0 and no check logic is built.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode constants (OP_LOAD = 7'b0000011, etc.);
  - the ALUOp and ALUControl encodings;
  - the NOP constant.
- One natural sub-module: regfile (2 read ports, 1 write port, with bypass and synchronous reset), instantiated once.

Test Plan:
- Reset: assert reset for 2 cycles, then release -> all control outputs 0, stall_f = 0, flush_e = 0, rs1_d = 0.
- Decode addi x5, x1, -3 (0xFFD08293) with x1 = 10:
  - RegWrite = 1, ALUSrc = 1, ALUOp = 011, ALUControl = 0000;
  - imm_d = 0xFFFFFFFD, rs1_d = 10, rd_id = 5.
- Load-use: MemRead_x = 1, rd_ex = 5, IF/ID holds add x6, x5, x2:
  - stall_f = 1, flush_e = 1, IF/ID unchanged next cycle;
  - with rd_ex = 0 -> no stall.
- Redirect: redirect_x = 1 coincident with hz:
  - stall_f = 0, flush_e = 1;
  - next cycle valid_q = 0 and all control outputs 0.
- WB bypass: wb_we = 1, wb_rd = 3, wb_data = 0xDEADBEEF while decoding rs1 = x3 -> rs1_d = 0xDEADBEEF in the same cycle.
- x0 protection: write wb_rd = 0 with data 0x1234 -> reading x0 returns 0.
